// File: rtl/elevator_car.sv
// elevator_car: behavioural plant model of an elevator car and its hoistway.
// Takes up/down/open commands from the controller, models per-floor travel
// time and the door dwell time, and reports floor, motion and door status.
// Optional feature macro: ELEVATOR_CAR_FAULT_EN enables a sticky flag on
// illegal command combinations; without it `fault` is tied low.
module elevator_car #(
    parameter int floor_numbers = 10,
    parameter int travel_cycles = 8,
    parameter int door_cycles   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       open,
    output logic [3:0] floor,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic       arrived,
    output logic       fault
);

    localparam int max_cycles = (travel_cycles > door_cycles) ? travel_cycles : door_cycles;
    localparam int cnt_w      = ($clog2(max_cycles) < 1) ? 1 : $clog2(max_cycles);

    localparam logic [cnt_w-1:0] travel_load = cnt_w'(travel_cycles - 1);
    localparam logic [cnt_w-1:0] door_load   = cnt_w'(door_cycles - 1);
    localparam logic [3:0]       top_floor   = 4'(floor_numbers - 1);

    typedef enum logic [1:0] {
        st_idle,
        st_move,
        st_door
    } state_t;

    state_t           state, state_nx;
    logic [cnt_w-1:0] cnt, cnt_nx;
    logic [3:0]       floor_nx;
    logic             dir_nx;
    logic             arrived_nx;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Next-state logic: command decode in IDLE, shared countdown in MOVE/DOOR.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        floor_nx   = floor;
        dir_nx     = dir_up;
        arrived_nx = 1'b0;
        case (state)
            st_idle: begin
                // open wins over motion; up/down together or past the end
                // of the shaft are simply ignored
                if (open) begin
                    state_nx = st_door;
                    cnt_nx   = door_load;
                end else if (up && !down && (floor < top_floor)) begin
                    state_nx = st_move;
                    dir_nx   = 1'b1;
                    cnt_nx   = travel_load;
                end else if (down && !up && (floor > 4'd0)) begin
                    state_nx = st_move;
                    dir_nx   = 1'b0;
                    cnt_nx   = travel_load;
                end
            end
            st_move: begin
                // a committed move ignores every command until it lands
                if (!cnt_zero) begin
                    cnt_nx = cnt - cnt_w'(1);
                end else begin
                    floor_nx   = dir_up ? (floor + 4'd1) : (floor - 4'd1);
                    arrived_nx = 1'b1;
                    state_nx   = st_idle;
                end
            end
            st_door: begin
                // after the minimum dwell, a held open keeps the door open
                // with the counter parked at zero
                if (!cnt_zero) begin
                    cnt_nx = cnt - cnt_w'(1);
                end else if (!open) begin
                    state_nx = st_idle;
                end
            end
            default: begin
                state_nx = st_idle;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, counter, floor and status registers; reset drops any move in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= st_idle;
            cnt     <= '0;
            floor   <= 4'd0;
            dir_up  <= 1'b1;
            arrived <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            floor   <= floor_nx;
            dir_up  <= dir_nx;
            arrived <= arrived_nx;
        end
    end

    assign moving    = (state == st_move);
    assign door_open = (state == st_door);

`ifdef ELEVATOR_CAR_FAULT_EN
    logic illegal;

    // Flag commands that the car is forced to ignore.
    always_comb begin
        illegal = (up && down)
               || ((state == st_door) && (up || down))
               || ((state == st_move) && open)
               || ((state == st_idle) && ((up && (floor == top_floor)) ||
                                          (down && (floor == 4'd0))));
    end

    // Sticky fault: once seen, held until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (illegal) begin
            fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_elevator_car.sv
// tb_elevator_car: directed scenarios plus randomized commands checked
// against an event-time reference model of the car.
module tb_elevator_car;

    localparam int floors = 10;
    localparam int travel = 8;
    localparam int dwell  = 4;
`ifdef ELEVATOR_CAR_FAULT_EN
    localparam bit fault_en = 1'b1;
`else
    localparam bit fault_en = 1'b0;
`endif

    logic       clock, reset, up, down, open;
    logic [3:0] floor;
    logic       moving, dir_up, door_open, arrived, fault;

    int checks = 0;
    int errors = 0;

    elevator_car #(
        .floor_numbers(floors),
        .travel_cycles(travel),
        .door_cycles  (dwell)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .up       (up),
        .down     (down),
        .open     (open),
        .floor    (floor),
        .moving   (moving),
        .dir_up   (dir_up),
        .door_open(door_open),
        .arrived  (arrived),
        .fault    (fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: the car is described by absolute edge times
    // (when the current move lands, when the door may close).
    int m_edge;
    int m_floor;
    bit m_dir;
    bit m_moving;
    bit m_door;
    bit m_arr;
    bit m_fault;
    int move_done_at;
    int door_min_at;

    task automatic model_reset();
        m_floor  = 0;
        m_dir    = 1'b1;
        m_moving = 1'b0;
        m_door   = 1'b0;
        m_arr    = 1'b0;
        m_fault  = 1'b0;
    endtask

    task automatic model_step(input bit u, input bit d, input bit o);
        bit idle;
        idle = !m_moving && !m_door;
        if (fault_en && ((u && d) || (m_door && (u || d)) || (m_moving && o) ||
                         (idle && ((u && m_floor == floors - 1) || (d && m_floor == 0)))))
            m_fault = 1'b1;
        m_arr = 1'b0;
        if (m_moving) begin
            if (m_edge == move_done_at) begin
                m_floor  = m_dir ? m_floor + 1 : m_floor - 1;
                m_arr    = 1'b1;
                m_moving = 1'b0;
            end
        end else if (m_door) begin
            if (m_edge >= door_min_at && !o) m_door = 1'b0;
        end else if (o) begin
            m_door      = 1'b1;
            door_min_at = m_edge + dwell;
        end else if (u && !d && m_floor < floors - 1) begin
            m_moving     = 1'b1;
            m_dir        = 1'b1;
            move_done_at = m_edge + travel;
        end else if (d && !u && m_floor > 0) begin
            m_moving     = 1'b1;
            m_dir        = 1'b0;
            move_done_at = m_edge + travel;
        end
        m_edge++;
    endtask

    task automatic tick(input bit u, input bit d, input bit o);
        up   = u;
        down = d;
        open = o;
        model_step(u, d, o);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        up    = 1'b0;
        down  = 1'b0;
        open  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        m_edge++;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (floor !== 4'd0 || moving !== 1'b0 || door_open !== 1'b0 ||
                arrived !== 1'b0 || fault !== 1'b0 || dir_up !== 1'b1) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got floor=%0d mov=%b door=%b arr=%b flt=%b dir=%b want 0 0 0 0 0 1",
                         i, floor, moving, door_open, arrived, fault, dir_up);
            end
        end
    endtask

    task automatic test_single_up();
        int mov_cnt;
        mov_cnt = 0;
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < travel; i++) begin
            if (moving === 1'b1) mov_cnt++;
            checks++;
            if (arrived !== 1'b0 || floor !== 4'd0) begin
                errors++;
                $display("FAIL single_up_early cyc=%0d got arr=%b floor=%0d want 0 0", i, arrived, floor);
            end
            tick(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (mov_cnt != travel) begin
            errors++;
            $display("FAIL single_up_moving_len got %0d want %0d", mov_cnt, travel);
        end
        checks++;
        if (floor !== 4'd1 || arrived !== 1'b1 || moving !== 1'b0 || dir_up !== 1'b1) begin
            errors++;
            $display("FAIL single_up_arrive got floor=%0d arr=%b mov=%b dir=%b want 1 1 0 1",
                     floor, arrived, moving, dir_up);
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (arrived !== 1'b0 || floor !== 4'd1) begin
            errors++;
            $display("FAIL single_up_pulse got arr=%b floor=%0d want 0 1", arrived, floor);
        end
    endtask

    task automatic test_saturate();
        int arr_cnt;
        bit over;
        arr_cnt = 0;
        over    = 1'b0;
        for (int i = 0; i < 8 * (travel + 1) + 20; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (arrived === 1'b1) arr_cnt++;
            if (floor > 4'd9) over = 1'b1;
        end
        checks++;
        if (floor !== 4'd9 || over || arr_cnt != 8 || moving !== 1'b0) begin
            errors++;
            $display("FAIL saturate got floor=%0d over=%b arrivals=%0d mov=%b want 9 0 8 0",
                     floor, over, arr_cnt, moving);
        end
        checks++;
        if (fault !== fault_en) begin
            errors++;
            $display("FAIL saturate_fault got %b want %b", fault, fault_en);
        end
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_door();
        int open_cnt;
        open_cnt = 0;
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (door_open === 1'b1) open_cnt++;
            checks++;
            if (door_open === 1'b1 && (moving === 1'b1 || arrived === 1'b1)) begin
                errors++;
                $display("FAIL door_exclusive got mov=%b arr=%b want 0 0", moving, arrived);
            end
            tick(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (open_cnt != dwell) begin
            errors++;
            $display("FAIL door_pulse_len got %0d want %0d", open_cnt, dwell);
        end
        open_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (door_open === 1'b1) open_cnt++;
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (door_open !== 1'b0) begin
            errors++;
            $display("FAIL door_release got %b want 0", door_open);
        end
        checks++;
        if (open_cnt != 10) begin
            errors++;
            $display("FAIL door_held_len got %0d want 10", open_cnt);
        end
    endtask

    task automatic test_up_down_together();
        do_reset();
        for (int i = 0; i < 3 * (travel + 1); i++) tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (floor !== 4'd3 || fault !== 1'b0) begin
            errors++;
            $display("FAIL updown_setup got floor=%0d flt=%b want 3 0", floor, fault);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            checks++;
            if (moving !== 1'b0 || floor !== 4'd3) begin
                errors++;
                $display("FAIL updown_motion got mov=%b floor=%0d want 0 3", moving, floor);
            end
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (fault !== fault_en) begin
            errors++;
            $display("FAIL updown_fault got %b want %b", fault, fault_en);
        end
    endtask

    task automatic test_reset_mid_move();
        bit saw_arr;
        saw_arr = 1'b0;
        do_reset();
        for (int i = 0; i < 2 * (travel + 1); i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (moving !== 1'b1 || floor !== 4'd2) begin
            errors++;
            $display("FAIL midmove_setup got mov=%b floor=%0d want 1 2", moving, floor);
        end
        do_reset();
        checks++;
        if (floor !== 4'd0 || moving !== 1'b0 || arrived !== 1'b0) begin
            errors++;
            $display("FAIL midmove_reset got floor=%0d mov=%b arr=%b want 0 0 0", floor, moving, arrived);
        end
        for (int i = 0; i < travel + 4; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (arrived === 1'b1 || moving === 1'b1) saw_arr = 1'b1;
        end
        checks++;
        if (saw_arr || floor !== 4'd0) begin
            errors++;
            $display("FAIL midmove_after got stray=%b floor=%0d want 0 0", saw_arr, floor);
        end
    endtask

    task automatic test_random();
        bit u, d, o;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                u = ($urandom_range(0, 2) == 0);
                d = ($urandom_range(0, 2) == 0);
                o = ($urandom_range(0, 5) == 0);
                tick(u, d, o);
            end
            checks++;
            if (int'(floor) != m_floor) begin
                errors++;
                $display("FAIL rand_floor cyc=%0d got %0d want %0d", i, floor, m_floor);
            end
            checks++;
            if (moving !== m_moving || door_open !== m_door) begin
                errors++;
                $display("FAIL rand_status cyc=%0d got mov=%b door=%b want %b %b", i, moving, door_open, m_moving, m_door);
            end
            checks++;
            if (arrived !== m_arr || dir_up !== m_dir) begin
                errors++;
                $display("FAIL rand_arr_dir cyc=%0d got arr=%b dir=%b want %b %b", i, arrived, dir_up, m_arr, m_dir);
            end
            checks++;
            if (fault !== m_fault) begin
                errors++;
                $display("FAIL rand_fault cyc=%0d got %b want %b", i, fault, m_fault);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        up     = 1'b0;
        down   = 1'b0;
        open   = 1'b0;
        m_edge = 0;
        move_done_at = 0;
        door_min_at  = 0;
        model_reset();
        test_reset();
        test_single_up();
        test_saturate();
        test_door();
        test_up_down_together();
        test_reset_mid_move();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
